// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared types and defaults for the serial frame transmitter.
//   - tx_state_e : transmitter FSM states (IDLE, SHIFT, GAP)
//   - DEF_*      : default parameter values
//   - frame_len(): serial bits per frame; one more than the word width when
//                  SERIAL_FRAME_TX_PARITY_EN is defined (trailing even-parity bit)
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    localparam int DEF_DATA_W       = 10;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_GAP_BITS     = 2;

    function automatic int frame_len(input int data_w);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/serial_bit_tick.sv
// serial_bit_tick
//   Bit-period divider for the serial frame transmitter. Counts clocks while
//   enabled and flags the last clock of each CLKS_PER_BIT-long bit period.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-low
//   clear_i : restart the bit period (frame accept)
//   en_i    : count this clock
//   tick_o  : last clock of the current bit period
//   cnt_o   : clock index within the current bit period
module serial_bit_tick #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          en_i,
    output logic          tick_o,
    output logic [CW-1:0] cnt_o
);

    assign tick_o = en_i && (cnt_o == CW'(CLKS_PER_BIT - 1));

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= tick_o ? '0 : cnt_o + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial frame transmitter. Accepts a DATA_W-bit word on a
//   valid/ready handshake and sends it LSB first, each bit held CLKS_PER_BIT
//   clocks, followed by GAP_BITS idle bit periods at level 0.
//   Optional feature macro: SERIAL_FRAME_TX_PARITY_EN appends an even-parity
//   bit (^word) after the payload.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-low
//   data_i  : word to transmit
//   valid_i : data_i valid
//   ready_o : word can be accepted this cycle (IDLE only)
//   data_o  : serial stream, LSB first, idle level 0
//   ena_o   : one-clock pulse on the first clock of bit 0
//   busy_o  : high from accept until the end of the gap
//   done_o  : one-clock pulse on the last clock of the final frame bit
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int GAP_BITS     = DEF_GAP_BITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              data_o,
    output logic              ena_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam int CW        = $clog2(CLKS_PER_BIT + 1);
    localparam int BW        = $clog2(FRAME_LEN + 1);
    localparam int GW        = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    tx_state_e            state;
    logic [FRAME_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] load_word;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_nxt;
    logic [GW-1:0]        gap_cnt;
    logic [CW-1:0]        clk_cnt;
    logic [CW-1:0]        clk_nxt;
    logic                 tick;
    logic                 accept;
    logic                 done_nxt;

    assign accept = ready_o && valid_i;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    assign load_word = {^data_i, data_i};
`else
    assign load_word = data_i;
`endif

    // The shift register empties to zero as it shifts, so the gap and idle
    // level come out of it for free.
    assign data_o = shreg[0];

    serial_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (accept),
        .en_i    (state != IDLE),
        .tick_o  (tick),
        .cnt_o   (clk_cnt)
    );

    // done_o is registered, so it is computed from the bit position the
    // transmitter will occupy on the next clock.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        clk_nxt  = tick ? '0 : clk_cnt + CW'(1);
        bit_nxt  = tick ? bit_cnt + BW'(1) : bit_cnt;
        done_nxt = (state == SHIFT) && (bit_nxt == BW'(FRAME_LEN - 1))
                   && (clk_nxt == CW'(CLKS_PER_BIT - 1));
        if (accept) begin
            done_nxt = (FRAME_LEN == 1) && (CLKS_PER_BIT == 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            ready_o <= 1'b1;
            ena_o   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            ena_o  <= accept;
            done_o <= done_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        shreg   <= load_word;
                        bit_cnt <= '0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == BW'(FRAME_LEN - 1)) begin
                            bit_cnt <= '0;
                            gap_cnt <= '0;
                            if (GAP_BITS == 0) begin
                                state   <= IDLE;
                                ready_o <= 1'b1;
                                busy_o  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_BITS - 1)) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Self-checking bench for serial_frame_tx (default parameters). A
//   cycle-level reference model expands every accepted word into its expected
//   output waveform and is compared against the DUT on every falling edge.
//   Table vectors, hand sequences (back-to-back, mid-frame reset, ignored
//   valid) and a randomized phase drive the stimulus.
module tb_serial_frame_tx;

    localparam int DATA_W = 10;
    localparam int CPB    = 4;
    localparam int GAP    = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif
    localparam int PERIOD = (FL + GAP) * CPB + 1;

    // {ready, data, ena, busy, done}
    localparam logic [4:0] IDLE_V = 5'b10000;

    logic              clk;
    logic              rst_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              data_o;
    logic              ena_o;
    logic              busy_o;
    logic              done_o;

    int total = 0;
    int bad   = 0;

    serial_frame_tx dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .ena_o   (ena_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0] exp_q[$];
    logic [4:0] cur = IDLE_V;
    bit         mon_en = 1'b0;
    int         model_acc = 0;

    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int b);
        if (b < DATA_W) return w[b];
        return ^w;
    endfunction

    task automatic push_frame(input logic [DATA_W-1:0] w);
        for (int b = 0; b < FL; b++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back({1'b0, frame_bit(w, b), (b == 0 && c == 0), 1'b1,
                                 (b == FL - 1 && c == CPB - 1)});
        for (int g = 0; g < GAP * CPB; g++)
            exp_q.push_back(5'b00010);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_i) begin
                exp_q.delete();
                cur = IDLE_V;
            end else begin
                if (cur[4] && valid_i) begin
                    push_frame(data_i);
                    model_acc++;
                end
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en)
            check("cycle_outputs", int'({ready_o, data_o, ena_o, busy_o, done_o}), int'(cur));
    end

    // ---------------- helpers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("ready_timeout", int'(ready_o), 1);
    endtask

    // Sends one word with a 1-clock valid and checks the whole frame; an
    // optional junk valid pulse is injected at frame clock `glitch`.
    task automatic send_frame(input logic [DATA_W-1:0] w, input logic [15:0] exp_frame,
                              input int glitch);
        logic [15:0] bits = '0;
        int ena_cnt = 0, done_cnt = 0, done_pos = 0, n = 0;
        logic ena0 = 1'b0;
        wait_ready();
        data_i  = w;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < FL * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) ena0 = ena_o;
            if (ena_o) ena_cnt++;
            if (done_o) begin
                done_cnt++;
                done_pos = i + 1;
            end
            if (i % CPB == CPB - 1) bits[i / CPB] = data_o;
            if (i == glitch) begin
                valid_i = 1'b1;
                data_i  = ~w;
            end else begin
                valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        check("frame_bits", int'(bits), int'(exp_frame));
        check("ena_first", int'(ena0), 1);
        check("ena_pulses", ena_cnt, 1);
        check("done_pulses", done_cnt, 1);
        check("done_clk", done_pos, FL * CPB);
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 300);
        check("gap_clks", n - 1, GAP * CPB);
    endtask

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              par;
        int                glitch;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int acc0;
        int ena_seen;
        logic [15:0] ef;
        logic [DATA_W-1:0] wa, wb;

        vecs[0] = '{10'b1100011011, 1'b0, -1};
        vecs[1] = '{10'h001,        1'b1, -1};
        vecs[2] = '{10'h3FF,        1'b0, -1};
        vecs[3] = '{10'h000,        1'b0, -1};
        vecs[4] = '{10'h2AA,        1'b1, 12};
        vecs[5] = '{10'h155,        1'b1, 25};

        // reset
        rst_i   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready_o), 1);
        check("rst_data", int'(data_o), 0);
        check("rst_ena", int'(ena_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        mon_en = 1'b1;
        rst_i  = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(ready_o), 1);

        // table vectors
        for (int v = 0; v < 6; v++) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ef = {5'b0, vecs[v].par, vecs[v].word};
`else
            ef = {6'b0, vecs[v].word};
`endif
            send_frame(vecs[v].word, ef, vecs[v].glitch);
        end

        // back-to-back with valid held high
        wa = 10'h2C7;
        wb = 10'h0B4;
        wait_ready();
        data_i  = wa;
        valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ena_o && n < 300);
        check("b2b_first_ena", int'(ena_o), 1);
        data_i = wb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ena_o && n < 300);
        check("b2b_period", n, PERIOD);
        valid_i = 1'b0;
        wait_ready();

        // reset in the middle of bit 5
        data_i  = 10'h3A5;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        check("midrst_data", int'(data_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_ready", int'(ready_o), 1);
        wa = 10'h1E6;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        ef = {5'b0, ^wa, wa};
`else
        ef = {6'b0, wa};
`endif
        send_frame(wa, ef, -1);

        // randomized traffic, scored cycle by cycle by the model
        acc0     = model_acc;
        ena_seen = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (ena_o) ena_seen++;
            valid_i = ($urandom_range(0, 2) == 0);
            data_i  = DATA_W'($urandom);
        end
        valid_i = 1'b0;
        repeat (PERIOD + 5) begin
            @(negedge clk);
            if (ena_o) ena_seen++;
        end
        check("rand_frames", ena_seen, model_acc - acc0);
        check("final_idle", int'(ready_o), 1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
